// File: rtl/fetch_queue_pkg.sv
// Shared constants and queue entry layout for the instruction prefetch queue.
package fetch_queue_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;
    localparam int unsigned ENTRY_W = 2 * XLEN;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & WORD_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Program-memory, CPU fetch handshake and redirect signals of the prefetch queue.
interface fetch_queue_if;
    import fetch_queue_pkg::*;

    logic [XLEN-1:0] pmAddress;
    logic [3:0]      pmWidth;
    logic [XLEN-1:0] pmDataIn;
    logic            fetch_valid;
    logic            fetch_ready;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] fetch_instr;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output pmAddress, pmWidth, fetch_valid, fetch_pc, fetch_instr,
        input  pmDataIn, fetch_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  pmAddress, pmWidth, fetch_valid, fetch_pc, fetch_instr,
        output pmDataIn, fetch_ready, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// DEPTH-entry {pc, instr} queue with push, pop and flush; head reads as zero when empty.
module fetch_fifo
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PtrW = $clog2(DEPTH)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    output fetch_entry_t head_o,
    output logic [PtrW:0] count_o,
    output logic         valid_o
);

    fetch_entry_t    mem_q [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW:0]   count_q, count_d;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({push_i, pop_i})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clock) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    always_comb begin
        valid_o = (count_q != '0);
        count_o = count_q;
        head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch stage: PC sequencing, issue credit, in-flight tracking and redirect.
// Define FETCH_QUEUE_TRACE_EN to print every push and redirect in simulation.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input logic          clock,
    input logic          reset,
    fetch_queue_if.master bus
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;
    localparam logic [CntW:0] CreditMax = (CntW + 1)'(DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic            inflight_q, inflight_d;
    logic [XLEN-1:0] redirect_addr;
    logic [XLEN-1:0] fetch_addr;
    logic [CntW:0]   credit;
    logic [CntW-1:0] fifo_count;
    logic            fifo_valid;
    logic            push, pop, issue;
    fetch_entry_t    push_data;
    fetch_entry_t    head;

    assign redirect_addr = word_align(bus.redirect_pc);
    assign fetch_addr    = bus.redirect_valid ? redirect_addr : fetch_pc_q;

    // Redirect suppresses both queue operations; the fifo sees it as a flush.
    assign pop  = fifo_valid & bus.fetch_ready & ~bus.redirect_valid;
    assign push = inflight_q & ~bus.redirect_valid;

    // Entries held plus the response already owed must leave room for a new fetch.
    assign credit = {1'b0, fifo_count} + {{CntW{1'b0}}, inflight_q} - {{CntW{1'b0}}, pop};
    assign issue  = bus.redirect_valid | (credit < CreditMax);

    assign push_data.pc    = inflight_pc_q;
    assign push_data.instr = bus.pmDataIn;

    always_comb begin
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        fetch_pc_d    = fetch_pc_q;
        if (issue) begin
            inflight_pc_d = fetch_addr;
            fetch_pc_d    = fetch_addr + 32'd4;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .flush_i     (bus.redirect_valid),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (fifo_count),
        .valid_o     (fifo_valid)
    );

    always_comb begin
        bus.pmAddress   = fetch_addr;
        bus.pmWidth     = 4'd4;
        bus.fetch_valid = fifo_valid;
        bus.fetch_pc    = head.pc;
        bus.fetch_instr = head.instr;
    end

`ifdef FETCH_QUEUE_TRACE_EN
    always @(posedge clock) begin
        if (reset) begin
            if (push) $write("%x: fetch %x\n", inflight_pc_q, bus.pmDataIn);
            if (bus.redirect_valid) $write("redirect %x\n", redirect_addr);
        end
    end
`else
    // Synthesis build: no trace output.
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus a randomized stream model.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pm_data;
    int          n_cmp  = 0;
    int          n_fail = 0;

    fetch_queue_if bus_if ();

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Synchronous program memory: data for the address seen at the edge.
    always @(posedge clk) pm_data <= word_at(bus_if.pmAddress);
    assign bus_if.pmDataIn = pm_data;

    // Holds reset two cycles, releases it on a falling edge: that cycle is cycle 0.
    task automatic start_stream(input logic ready);
        rst_n                 = 1'b0;
        bus_if.fetch_ready    = ready;
        bus_if.redirect_valid = 1'b0;
        bus_if.redirect_pc    = 32'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n                 = 1'b0;
        bus_if.fetch_ready    = 1'b0;
        bus_if.redirect_valid = 1'b0;
        bus_if.redirect_pc    = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (bus_if.pmAddress !== RESET_PC) begin
            n_fail++; $display("FAIL reset_pmAddress: got %h want %h", bus_if.pmAddress, RESET_PC);
        end
        n_cmp++;
        if (bus_if.pmWidth !== 4'd4) begin
            n_fail++; $display("FAIL reset_pmWidth: got %h want 4", bus_if.pmWidth);
        end
        n_cmp++;
        if (bus_if.fetch_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b want 0", bus_if.fetch_valid);
        end
        n_cmp++;
        if (bus_if.fetch_pc !== 32'h0 || bus_if.fetch_instr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_head: got pc %h instr %h want 0 0", bus_if.fetch_pc,
                     bus_if.fetch_instr);
        end
        n_cmp++;
        if (dut.fifo_count !== '0) begin
            n_fail++; $display("FAIL reset_count: got %0d want 0", dut.fifo_count);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        start_stream(1'b1);
        for (int k = 0; k < 7; k++) begin
            #1;
            n_cmp++;
            if (bus_if.fetch_valid !== (k >= 2)) begin
                n_fail++;
                $display("FAIL stream_valid cyc%0d: got %b want %b", k, bus_if.fetch_valid, k >= 2);
            end
            if (k >= 2) begin
                exp_pc = RESET_PC + 32'((k - 2) * 4);
                n_cmp++;
                if (bus_if.fetch_pc !== exp_pc || bus_if.fetch_instr !== word_at(exp_pc)) begin
                    n_fail++;
                    $display("FAIL stream_head cyc%0d: got %h/%h want %h/%h", k, bus_if.fetch_pc,
                             bus_if.fetch_instr, exp_pc, word_at(exp_pc));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc;
        start_stream(1'b0);
        repeat (10) @(negedge clk);
        #1;
        n_cmp++;
        if (dut.fifo_count !== 3'(DEPTH)) begin
            n_fail++; $display("FAIL bp_count: got %0d want %0d", dut.fifo_count, DEPTH);
        end
        n_cmp++;
        if (bus_if.pmAddress !== 32'h10) begin
            n_fail++; $display("FAIL bp_pmAddress: got %h want 00000010", bus_if.pmAddress);
        end
        n_cmp++;
        if (bus_if.fetch_valid !== 1'b1 || bus_if.fetch_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL bp_head: got v%b pc %h want v1 pc 0", bus_if.fetch_valid,
                     bus_if.fetch_pc);
        end
        @(negedge clk);
        bus_if.fetch_ready = 1'b1;
        exp_pc = 32'h0;
        // Drain at full rate: one entry per cycle, contiguous, never above DEPTH.
        for (int k = 0; k < 20; k++) begin
            #1;
            n_cmp++;
            if (bus_if.fetch_valid !== 1'b1 || bus_if.fetch_pc !== exp_pc ||
                bus_if.fetch_instr !== word_at(exp_pc) || dut.fifo_count > 3'(DEPTH)) begin
                n_fail++;
                $display("FAIL bp_drain cyc%0d: got v%b %h/%h cnt %0d want v1 %h/%h", k,
                         bus_if.fetch_valid, bus_if.fetch_pc, bus_if.fetch_instr,
                         dut.fifo_count, exp_pc, word_at(exp_pc));
            end
            exp_pc += 32'd4;
            @(negedge clk);
        end
    endtask

    task automatic test_redirect();
        logic found;
        logic [31:0] exp_pc;
        start_stream(1'b0);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            #1;
            if (dut.fifo_count == 3'd3 && dut.inflight_q) found = 1'b1;
            else @(negedge clk);
        end
        n_cmp++;
        if (!found) begin
            n_fail++; $display("FAIL redir_setup: got no 3-queued+inflight state want one");
        end
        bus_if.fetch_ready    = 1'b1;
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 32'h40;
        #1;
        n_cmp++;
        if (bus_if.pmAddress !== 32'h40) begin
            n_fail++; $display("FAIL redir_pmAddress: got %h want 00000040", bus_if.pmAddress);
        end
        @(negedge clk);
        bus_if.redirect_valid = 1'b0;
        #1;
        n_cmp++;
        if (bus_if.fetch_valid !== 1'b0) begin
            n_fail++; $display("FAIL redir_bubble: got %b want 0", bus_if.fetch_valid);
        end
        exp_pc = 32'h40;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (bus_if.fetch_valid !== 1'b1 || bus_if.fetch_pc !== exp_pc ||
                bus_if.fetch_instr !== word_at(exp_pc)) begin
                n_fail++;
                $display("FAIL redir_head%0d: got v%b %h/%h want v1 %h/%h", k, bus_if.fetch_valid,
                         bus_if.fetch_pc, bus_if.fetch_instr, exp_pc, word_at(exp_pc));
            end
            exp_pc += 32'd4;
        end
        @(negedge clk);
    endtask

    task automatic test_misaligned();
        start_stream(1'b1);
        repeat (3) @(negedge clk);
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 32'h43;
        #1;
        n_cmp++;
        if (bus_if.pmAddress !== 32'h40) begin
            n_fail++; $display("FAIL misalign_pmAddress: got %h want 00000040", bus_if.pmAddress);
        end
        @(negedge clk);
        bus_if.redirect_valid = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++;
        if (bus_if.fetch_valid !== 1'b1 || bus_if.fetch_pc !== 32'h40 ||
            bus_if.fetch_instr !== word_at(32'h40)) begin
            n_fail++;
            $display("FAIL misalign_head: got v%b %h/%h want v1 00000040/%h", bus_if.fetch_valid,
                     bus_if.fetch_pc, bus_if.fetch_instr, word_at(32'h40));
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        start_stream(1'b1);
        bus_if.redirect_pc = 32'hFFFF_FFFC;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus_if.fetch_valid !== 1'b0 || dut.fifo_count !== '0 ||
            bus_if.pmAddress !== RESET_PC) begin
            n_fail++;
            $display("FAIL midrst_state: got v%b cnt %0d addr %h want v0 cnt 0 addr %h",
                     bus_if.fetch_valid, dut.fifo_count, bus_if.pmAddress, RESET_PC);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (bus_if.fetch_valid !== 1'b1 || bus_if.fetch_pc !== RESET_PC ||
            bus_if.fetch_instr !== word_at(RESET_PC)) begin
            n_fail++;
            $display("FAIL midrst_head: got v%b %h/%h want v1 %h/%h", bus_if.fetch_valid,
                     bus_if.fetch_pc, bus_if.fetch_instr, RESET_PC, word_at(RESET_PC));
        end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc;
        start_stream(1'b1);
        repeat (3) @(negedge clk);
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 32'hFFFF_FFFC;
        @(negedge clk);
        bus_if.redirect_valid = 1'b0;
        exp_pc = 32'hFFFF_FFFC;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (bus_if.fetch_valid !== 1'b1 || bus_if.fetch_pc !== exp_pc ||
                bus_if.fetch_instr !== word_at(exp_pc)) begin
                n_fail++;
                $display("FAIL wrap_head%0d: got v%b %h/%h want v1 %h/%h", k, bus_if.fetch_valid,
                         bus_if.fetch_pc, bus_if.fetch_instr, exp_pc, word_at(exp_pc));
            end
            exp_pc += 32'd4;
        end
        @(negedge clk);
    endtask

    // Stream model: after a restart at address A (reset or redirect in cycle 0),
    // the head is valid from cycle 2 on and shows A, A+4, ... advancing on each accept.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] rpc;
        int          since;
        int          errs;
        start_stream(1'b0);
        exp_pc = RESET_PC;
        since  = 0;
        errs   = 0;
        for (int i = 0; i < 400; i++) begin
            rpc = $urandom;
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
            bus_if.fetch_ready    = ($urandom_range(0, 9) < 7);
            bus_if.redirect_valid = ($urandom_range(0, 99) < 6);
            bus_if.redirect_pc    = rpc;
            #1;
            n_cmp++;
            if (bus_if.fetch_valid !== (since >= 2)) begin
                n_fail++; errs++;
                $display("FAIL rand_valid i%0d: got %b want %b", i, bus_if.fetch_valid,
                         since >= 2);
            end
            n_cmp++;
            if (since >= 2) begin
                if (bus_if.fetch_pc !== exp_pc || bus_if.fetch_instr !== word_at(exp_pc)) begin
                    n_fail++; errs++;
                    $display("FAIL rand_head i%0d: got %h/%h want %h/%h", i, bus_if.fetch_pc,
                             bus_if.fetch_instr, exp_pc, word_at(exp_pc));
                end
            end else if (bus_if.fetch_pc !== 32'h0 || bus_if.fetch_instr !== 32'h0) begin
                n_fail++; errs++;
                $display("FAIL rand_empty i%0d: got %h/%h want 0/0", i, bus_if.fetch_pc,
                         bus_if.fetch_instr);
            end
            n_cmp++;
            if (bus_if.pmAddress[1:0] !== 2'b00 || dut.fifo_count > 3'(DEPTH) ||
                (bus_if.redirect_valid && bus_if.pmAddress !== (rpc & 32'hFFFF_FFFC))) begin
                n_fail++; errs++;
                $display("FAIL rand_addr i%0d: got addr %h cnt %0d (rv %b rpc %h)", i,
                         bus_if.pmAddress, dut.fifo_count, bus_if.redirect_valid, rpc);
            end
            if (bus_if.redirect_valid) begin
                exp_pc = rpc & 32'hFFFF_FFFC;
                since  = 1;
            end else begin
                if (since >= 2 && bus_if.fetch_ready) exp_pc += 32'd4;
                since++;
            end
            @(negedge clk);
            if (errs > 10) break;
        end
        bus_if.redirect_valid = 1'b0;
    endtask

    initial begin
        bus_if.fetch_ready    = 1'b0;
        bus_if.redirect_valid = 1'b0;
        bus_if.redirect_pc    = 32'h0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_misaligned();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "bench timed out");
    end

endmodule
